// File: rtl/uart_rx_mmio_if.sv
// ============================================================================
// uart_rx_mmio_if : data-bus port bundle for the memory-mapped UART receiver
// Revision 1.0
// ============================================================================
`default_nettype none

interface uart_rx_mmio_if;
    logic        en_i;
    logic [3:0]  we_i;
    logic [3:0]  addr_i;
    logic [31:0] data_i;
    logic [31:0] data_o;

    modport master (output en_i, we_i, addr_i, data_i, input  data_o);
    modport slave  (input  en_i, we_i, addr_i, data_i, output data_o);
endinterface

`default_nettype wire

// File: rtl/uart_rx_mmio.sv
// ============================================================================
// uart_rx_mmio : 8N1 serial receiver with byte FIFO, MMIO registers and IRQ.
// Optional even-parity frame via `define UART_RX_PARITY_EN.   Revision 1.0
// ============================================================================
`default_nettype none

module uart_rx_mmio #(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd16
) (
    input  wire logic     clk,
    input  wire logic     reset_n,
    uart_rx_mmio_if.slave bus_if,
    input  wire logic     rx_i,
    output logic          irq_o
);
    localparam int c_AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t      r_state;
    logic        r_rx_meta, r_rx_s, r_armed;
    logic [15:0] r_cnt, r_div;
    logic [2:0]  r_idx;
    logic [7:0]  r_shift;
    logic        r_irq_en, r_ovr, r_ferr, r_irq;
    logic [31:0] r_data_o;
    logic [7:0]  r_mem [FIFO_DEPTH];
    logic [c_AW-1:0] r_wptr, r_rptr;
    logic [c_AW:0]   r_count;

    logic        w_rd, w_wr, w_empty, w_full, w_pop, w_expire, w_stop_hit;
    logic        w_push, w_push_ok, w_ovr_set, w_ferr_set, w_stat_wr;
    logic        w_perr, w_par_bad;
    logic [1:0]  w_sel;
    logic [8:0]  w_count9;
    logic [7:0]  w_count8;
    logic [31:0] w_rdata;
    logic        w_unused_ok;

    assign w_sel      = bus_if.addr_i[3:2];
    assign w_rd       = bus_if.en_i && (bus_if.we_i == 4'h0);
    assign w_wr       = bus_if.en_i && (bus_if.we_i != 4'h0);
    assign w_stat_wr  = w_wr && (w_sel == 2'd1);
    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == (c_AW+1)'(FIFO_DEPTH));
    assign w_pop      = w_rd && (w_sel == 2'd0) && !w_empty;
    assign w_expire   = (r_cnt == 16'd0);
    assign w_stop_hit = (r_state == S_STOP) && w_expire;
    assign w_push     = w_stop_hit && r_rx_s && !w_par_bad;
    assign w_ferr_set = w_stop_hit && !r_rx_s;
    // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
    assign w_push_ok  = w_push && (!w_full || w_pop);
    assign w_ovr_set  = w_push && w_full && !w_pop;
    assign w_count9   = 9'(r_count);
    assign w_count8   = w_count9[8] ? 8'hFF : w_count9[7:0];
    assign w_unused_ok = &{1'b0, bus_if.addr_i[1:0], bus_if.data_i[31:16]};

`ifdef UART_RX_PARITY_EN
    logic r_perr, r_par_bad, w_perr_set;
    assign w_perr     = r_perr;
    assign w_par_bad  = r_par_bad;
    assign w_perr_set = (r_state == S_PARITY) && w_expire && ((^r_shift) != r_rx_s);
`else
    assign w_perr     = 1'b0;
    assign w_par_bad  = 1'b0;
`endif

    always_comb begin
        w_rdata = 32'h0;
        case (w_sel)
            2'd0: w_rdata = w_empty ? 32'h8000_0000 : {24'h0, r_mem[r_rptr]};
            2'd1: w_rdata = {16'h0, w_count8, 3'b000, w_perr, r_ferr, r_ovr, w_full, !w_empty};
            2'd2: w_rdata = {31'h0, r_irq_en};
            default: w_rdata = {16'h0, r_div};
        endcase
    end

    // Receiver FSM; r_armed blocks re-detection of a held break after STOP.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_state   <= S_IDLE;
            r_armed   <= 1'b1;
            r_cnt     <= 16'd0;
            r_idx     <= 3'd0;
            r_shift   <= 8'h00;
`ifdef UART_RX_PARITY_EN
            r_par_bad <= 1'b0;
`endif
        end else begin
            r_rx_meta <= rx_i;
            r_rx_s    <= r_rx_meta;
            case (r_state)
                S_IDLE: begin
                    r_armed <= r_rx_s;
                    if (!r_rx_s && r_armed) begin
                        r_state <= S_START;
                        r_cnt   <= r_div >> 1;
                    end
                end
                S_START: begin
                    if (!w_expire) begin
                        r_cnt <= r_cnt - 16'd1;
                    end else if (!r_rx_s) begin
                        r_state <= S_DATA;
                        r_cnt   <= r_div - 16'd1;
                        r_idx   <= 3'd0;
`ifdef UART_RX_PARITY_EN
                        r_par_bad <= 1'b0;
`endif
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_DATA: begin
                    if (!w_expire) begin
                        r_cnt <= r_cnt - 16'd1;
                    end else begin
                        r_shift[r_idx] <= r_rx_s;
                        r_cnt          <= r_div - 16'd1;
                        r_idx          <= r_idx + 3'd1;
                        if (r_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= S_PARITY;
`else
                            r_state <= S_STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (!w_expire) begin
                        r_cnt <= r_cnt - 16'd1;
                    end else begin
                        r_par_bad <= ((^r_shift) != r_rx_s);
                        r_cnt     <= r_div - 16'd1;
                        r_state   <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (!w_expire) r_cnt <= r_cnt - 16'd1;
                    else           r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wptr] <= r_shift;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div    <= DIV_RESET;
            r_irq_en <= 1'b0;
            r_ovr    <= 1'b0;
            r_ferr   <= 1'b0;
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_data_o <= 32'h0;
            r_irq    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_perr   <= 1'b0;
`endif
        end else begin
            if (w_wr && (w_sel == 2'd2)) r_irq_en <= bus_if.data_i[0];
            if (w_wr && (w_sel == 2'd3))
                r_div <= (bus_if.data_i[15:1] == 15'd0) ? 16'd2 : bus_if.data_i[15:0];
            r_ovr  <= (r_ovr  && !(w_stat_wr && bus_if.data_i[2])) || w_ovr_set;
            r_ferr <= (r_ferr && !(w_stat_wr && bus_if.data_i[3])) || w_ferr_set;
`ifdef UART_RX_PARITY_EN
            r_perr <= (r_perr && !(w_stat_wr && bus_if.data_i[4])) || w_perr_set;
`endif
            if (w_push_ok) r_wptr <= r_wptr + 1'b1;
            if (w_pop)     r_rptr <= r_rptr + 1'b1;
            if (w_push_ok && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push_ok && w_pop) r_count <= r_count - 1'b1;
            if (w_rd) r_data_o <= w_rdata;
            r_irq <= r_irq_en && (!w_empty || r_ovr || r_ferr || w_perr);
        end
    end

    assign bus_if.data_o = r_data_o;
    assign irq_o         = r_irq;
endmodule

`default_nettype wire

// File: tb/tb_uart_rx_mmio.sv
// ============================================================================
// tb_uart_rx_mmio : directed + random frames checked against a queue model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_uart_rx_mmio;
    localparam int DEPTH = 8;
`ifdef UART_RX_PARITY_EN
    localparam int NPAR = 1;
`else
    localparam int NPAR = 0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic rx_i = 1'b1;
    logic irq_o;
    uart_rx_mmio_if bus ();

    uart_rx_mmio #(.FIFO_DEPTH(DEPTH), .DIV_RESET(16'd16)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus_if (bus),
        .rx_i   (rx_i),
        .irq_o  (irq_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int div = 16;
    logic [7:0] q[$];
    bit m_ovr = 0, m_ferr = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_status();
        int n = q.size();
        logic [7:0] n8 = (n > 255) ? 8'hFF : 8'(n);
        return {16'h0, n8, 3'b000, 1'b0, m_ferr, m_ovr, (n == DEPTH), (n != 0)};
    endfunction

    // Rising edge at which the stop bit is sampled, counting from the negedge that drives the start bit.
    function automatic int stop_edge();
        return 4 + (div >> 1) + div * (9 + NPAR);
    endfunction

    function automatic void model_rx(input logic [7:0] b);
        if (q.size() == DEPTH) m_ovr = 1;
        else q.push_back(b);
    endfunction

    task automatic bus_rd(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.en_i = 1'b1; bus.we_i = 4'h0; bus.addr_i = a;
        @(negedge clk);
        bus.en_i = 1'b0;
        d = bus.data_o;
    endtask

    task automatic bus_wr(input logic [3:0] a, input logic [31:0] v);
        @(negedge clk);
        bus.en_i = 1'b1; bus.we_i = 4'hF; bus.addr_i = a; bus.data_i = v;
        @(negedge clk);
        bus.en_i = 1'b0; bus.we_i = 4'h0;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_ok);
        @(negedge clk);
        rx_i = 1'b0;
        repeat (div) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_i = b[i];
            repeat (div) @(negedge clk);
        end
        if (NPAR != 0) begin
            rx_i = ^b;
            repeat (div) @(negedge clk);
        end
        rx_i = stop_ok;
        repeat (div) @(negedge clk);
        rx_i = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic check_status(input string tag);
        logic [31:0] d;
        bus_rd(4'h4, d);
        check(tag, d, exp_status());
    endtask

    task automatic drain(input string tag);
        logic [31:0] d;
        while (q.size() != 0) begin
            bus_rd(4'h0, d);
            check(tag, d, {24'h0, q.pop_front()});
        end
        bus_rd(4'h0, d);
        check({tag, "_empty"}, d, 32'h8000_0000);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] d;
        logic [7:0]  b;
        bus.en_i = 1'b0; bus.we_i = 4'h0; bus.addr_i = 4'h0; bus.data_i = 32'h0;

        repeat (3) @(negedge clk);
        check("rst_irq", {31'h0, irq_o}, 32'h0);
        check("rst_data", bus.data_o, 32'h0);
        reset_n = 1'b1;
        check_status("rst_status");
        bus_rd(4'hC, d); check("rst_div", d, 32'h10);
        bus_rd(4'h8, d); check("rst_ctrl", d, 32'h0);

        // Two directed bytes, then an empty read.
        send_frame(8'h55, 1'b1); model_rx(8'h55);
        send_frame(8'hA3, 1'b1); model_rx(8'hA3);
        check_status("t1_status2");
        drain("t1_rx");
        check_status("t1_status0");

        // Short low pulse must be rejected at the start-bit sample.
        @(negedge clk); rx_i = 1'b0;
        repeat (4) @(negedge clk); rx_i = 1'b1;
        repeat (40) @(negedge clk);
        check_status("t2_glitch");

        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom); send_frame(b, 1'b1); model_rx(b);
        end
        check_status("rand_status");
        drain("rand_rx");

        // Divisor clamp and a random divisor.
        bus_wr(4'hC, 32'h1); bus_rd(4'hC, d); check("div_clamp1", d, 32'h2);
        bus_wr(4'hC, 32'h0); bus_rd(4'hC, d); check("div_clamp0", d, 32'h2);
        div = int'($urandom_range(8, 24));
        bus_wr(4'hC, 32'(div));
        for (int i = 0; i < 2; i++) begin
            b = 8'($urandom); send_frame(b, 1'b1); model_rx(b);
        end
        drain("div_rx");
        div = 16; bus_wr(4'hC, 32'h10);

        // Interrupt rises one edge after the stop-bit push and falls after the pop.
        bus_wr(4'h8, 32'h1);
        check("t5_irq_idle", {31'h0, irq_o}, 32'h0);
        fork
            send_frame(8'h41, 1'b1);
            begin
                @(negedge clk);
                repeat (stop_edge()) @(negedge clk);
                check("t5_irq_pre", {31'h0, irq_o}, 32'h0);
                @(negedge clk);
                check("t5_irq_post", {31'h0, irq_o}, 32'h1);
            end
        join
        model_rx(8'h41);
        bus_rd(4'h0, d); check("t5_rx", d, {24'h0, q.pop_front()});
        repeat (2) @(negedge clk);
        check("t5_irq_fall", {31'h0, irq_o}, 32'h0);

        // Frame error: no push, sticky flag, IRQ, write-1-to-clear.
        send_frame(8'($urandom), 1'b0); m_ferr = 1;
        check_status("t4_ferr");
        check("t4_irq", {31'h0, irq_o}, 32'h1);
        bus_wr(4'h4, 32'h8); m_ferr = 0;
        check_status("t4_clear");
        repeat (2) @(negedge clk);
        check("t4_irq_clr", {31'h0, irq_o}, 32'h0);
        bus_wr(4'h8, 32'h0);

        // Nine bytes into eight entries.
        for (int i = 0; i < 9; i++) begin
            b = 8'($urandom); send_frame(b, 1'b1); model_rx(b);
        end
        check_status("t3_full");
        check("t3_literal", exp_status(), 32'h0000_0807);
        bus_wr(4'h4, 32'h4); m_ovr = 0;
        check_status("t3_ovr_clr");

        // Read on the same edge that the stop sample pushes into a full FIFO.
        b = 8'($urandom);
        fork
            send_frame(b, 1'b1);
            begin
                @(negedge clk);
                repeat (stop_edge() - 2) @(negedge clk);
                bus_rd(4'h0, d);
                check("t6_pop", d, {24'h0, q.pop_front()});
            end
        join
        model_rx(b);
        check_status("t6_status");
        drain("t6_rx");

        // Reset mid-frame with live outputs.
        b = 8'($urandom); send_frame(b, 1'b1); model_rx(b);
        bus_wr(4'h8, 32'h1);
        bus_rd(4'h4, d); check("t7_pre", d, exp_status());
        check("t7_pre_irq", {31'h0, irq_o}, 32'h1);
        @(negedge clk); rx_i = 1'b0;
        repeat (40) @(negedge clk);
        reset_n = 1'b0; rx_i = 1'b1;
        #1;
        check("t7_rst_data", bus.data_o, 32'h0);
        check("t7_rst_irq", {31'h0, irq_o}, 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        q.delete(); m_ovr = 0; m_ferr = 0;
        repeat (200) @(negedge clk);
        check_status("t7_status");
        bus_rd(4'h8, d); check("t7_ctrl", d, 32'h0);
        bus_rd(4'hC, d); check("t7_div", d, 32'h10);
        bus_rd(4'h0, d); check("t7_empty", d, 32'h8000_0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

`default_nettype wire
